if_fetch: RTL
=============

# if_fetch

Instruction-fetch front end of the RISC-V core. Advances only on `tick`, the one-clock-in-four strobe from the clock divider. On each tick it reads one byte over an 8-bit memory port, and it assembles four bytes into a little-endian 32-bit instruction. The assembled instruction is handed to the decode stage through a valid/ready handshake, and a branch redirect from execute can abort any fetch in progress.

## Interface
- `PC_RESET`, default 32'h0000_0000: PC value loaded on reset.
- `clk` in 1: system clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `tick` in 1: step strobe from the clock divider; a one-`clk`-wide pulse, at least 4 clocks apart.
- `mem_a` out 32: byte address presented to instruction memory.
- `mem_rd` out 1: read request; high while a fetch is in progress.
- `mem_din` in 8: read data. The byte for an address issued on one tick is valid at the next tick.
- `br_taken` in 1: redirect pulse; sampled every `clk` and not gated by `tick`.
- `br_target` in 32: new PC, valid while `br_taken` is high.
- `inst_valid` out 1: `inst` and `inst_pc` hold a complete instruction.
- `inst` out 32: assembled instruction; byte at `inst_pc` goes to [7:0].
- `inst_pc` out 32: address of `inst`.
- `inst_ready` in 1: decode accepts; a transfer occurs on any `clk` edge where `inst_valid` and `inst_ready` are both high.

## Operation
- The state machine has six states: REQ, B0, B1, B2, B3 and HOLD. Its register is `pc`.
- REQ, on tick: `mem_a` is set to `pc`, `mem_rd` is set to 1, and the next state is B0.
- Bi for i = 0..2, on tick: `mem_din` is captured into `inst[8i+7:8i]`, `mem_a` is set to `pc+i+1`, and the next state is B(i+1).
- B3, on tick: `mem_din` is captured into `inst[31:24]`, `mem_rd` is set to 0, `inst_pc` is set to `pc`, `inst_valid` is set to 1, and the next state is HOLD.
- HOLD:
  - `inst`, `inst_pc` and `inst_valid` stay stable until a transfer.
  - On transfer, `inst_valid` goes to 0, `pc` becomes `pc+4`, and the next state is REQ.
  - Ticks are ignored in HOLD.
- In any state, a clock with no tick, no `br_taken` and no transfer leaves every register unchanged.
- Redirect, on any state and any cycle where `br_taken` = 1:
  - `pc` is loaded with `br_target`, `mem_rd` goes to 0, `inst_valid` goes to 0, and the next state is REQ.
  - Partial bytes are discarded.
  - Redirect has priority over tick.
  - If a transfer occurs on the same edge, the transfer still counts as accepted and `pc` takes `br_target`, not `pc+4`.
- Arithmetic: all address sums are 32-bit modulo 2^32.
  - `pc+i` wraps, so 0xFFFF_FFFF+1 = 0x0000_0000.
  - The `br_target` low bits are used unmodified (byte addressing); no alignment check is made.
- `mem_a` holds its last value when `mem_rd` = 0.

## Timing
- Reset values, applied asynchronously while `rst` = 0:
  - `pc` = PC_RESET and state = REQ.
  - `mem_a` = 0, `mem_rd` = 0.
  - `inst` = 0, `inst_pc` = 0, `inst_valid` = 0.
- Reset asserted mid-fetch aborts the fetch immediately, without waiting for a clock.
- Reset release: the first tick after `rst` goes high starts the fetch at PC_RESET.
- Latency: `inst_valid` rises on the 5th tick after REQ is entered, i.e. 5 ticks = 20 clocks at a steady divider.
- Throughput: 5 ticks per instruction when `inst_ready` is held at 1. The tick that falls in the same cycle as the transfer is not used.
- `mem_a` and `mem_rd` are registered and change only on tick edges or on redirect/reset.
- A transfer takes one `clk`. `inst_valid` falls on the edge after the transfer.

## Test plan
- **Basic fetch:** reset, then release with memory[0..3] = 13,05,10,00 and ticks every 4 clocks.
  - `mem_a` must step 0,1,2,3 on successive ticks.
  - On the 5th tick, `inst_valid` = 1, `inst` = 0x00100513 and `inst_pc` = 0.
- **Backpressure:** hold `inst_ready` = 0 for 40 clocks after valid.
  - `inst`, `inst_pc` and `inst_valid` must be stable and `mem_rd` = 0.
  - Raise ready: the transfer occurs in that clock and the next fetch issues `mem_a` = 4.
- **Redirect mid-fetch:** pulse `br_taken` with `br_target` = 0x100 in state B1, between ticks.
  - `mem_rd` must be 0 on the next edge.
  - The next tick issues 0x100, and the resulting `inst_pc` = 0x100.
- **Redirect with transfer:** in HOLD, assert `inst_ready` and `br_taken` (target 0x40) in the same clock.
  - `inst_valid` must drop.
  - The next fetch must start at 0x40, not `inst_pc`+4.
- **Wrap-around:** with PC_RESET = 0xFFFF_FFFC, run one instruction and accept it.
  - `mem_a` must be FFFF_FFFC..FFFF_FFFF, then the next fetch starts at 0x0000_0000.
- **Asynchronous reset:** drive `rst` = 0 during B2 between clock edges.
  - All outputs take their reset values before the next `clk` edge.
  - After release, the fetch restarts at PC_RESET.

Source files
------------

// File: rtl/if_fetch_if.sv
// Bundle between the fetch front end, instruction memory, execute redirect and decode.
// The fetch unit is the master: it drives the memory request and the instruction
// handoff, and it receives memory data, redirects and decode's ready.
interface if_fetch_if;
   logic [31:0] mem_a;
   logic        mem_rd;
   logic [7:0]  mem_din;
   logic        br_taken;
   logic [31:0] br_target;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;

   modport master (
      output mem_a, mem_rd, inst_valid, inst, inst_pc,
      input  mem_din, br_taken, br_target, inst_ready
   );

   modport slave (
      input  mem_a, mem_rd, inst_valid, inst, inst_pc,
      output mem_din, br_taken, br_target, inst_ready
   );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch front end: walks four byte reads over an 8-bit memory port,
// one per divider tick, assembles a little-endian 32-bit word and offers it to
// decode with valid/ready. A branch redirect aborts whatever is in flight.
module if_fetch #(
   parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick,
   if_fetch_if.master  bus
);

   typedef enum logic [2:0] {
      S_REQ  = 3'd0,
      S_B0   = 3'd1,
      S_B1   = 3'd2,
      S_B2   = 3'd3,
      S_B3   = 3'd4,
      S_HOLD = 3'd5
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] mem_a_q, mem_a_d;
   logic        mem_rd_q, mem_rd_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] inst_pc_q, inst_pc_d;
   logic        inst_valid_q, inst_valid_d;
   logic        xfer;

   // A handoff to decode happens whenever a held word meets ready.
   assign xfer = inst_valid_q & bus.inst_ready;

   // Next-state logic: redirect wins over everything, otherwise step on tick
   // (or on transfer while holding a finished word).
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      mem_a_d      = mem_a_q;
      mem_rd_d     = mem_rd_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      inst_valid_d = inst_valid_q;

      if (bus.br_taken) begin
         // Partial bytes are simply abandoned; a transfer on this same edge
         // still happened from decode's point of view, but pc follows the branch.
         pc_d         = bus.br_target;
         mem_rd_d     = 1'b0;
         inst_valid_d = 1'b0;
         state_d      = S_REQ;
      end else begin
         unique case (state_q)
            S_REQ: begin
               if (tick) begin
                  mem_a_d  = pc_q;
                  mem_rd_d = 1'b1;
                  state_d  = S_B0;
               end
            end
            S_B0: begin
               if (tick) begin
                  inst_d[7:0] = bus.mem_din;
                  mem_a_d     = pc_q + 32'd1;
                  state_d     = S_B1;
               end
            end
            S_B1: begin
               if (tick) begin
                  inst_d[15:8] = bus.mem_din;
                  mem_a_d      = pc_q + 32'd2;
                  state_d      = S_B2;
               end
            end
            S_B2: begin
               if (tick) begin
                  inst_d[23:16] = bus.mem_din;
                  mem_a_d       = pc_q + 32'd3;
                  state_d       = S_B3;
               end
            end
            S_B3: begin
               if (tick) begin
                  inst_d[31:24] = bus.mem_din;
                  mem_rd_d      = 1'b0;
                  inst_pc_d     = pc_q;
                  inst_valid_d  = 1'b1;
                  state_d       = S_HOLD;
               end
            end
            S_HOLD: begin
               // Ticks landing here are dropped; only decode can release the word.
               if (xfer) begin
                  inst_valid_d = 1'b0;
                  pc_d         = pc_q + 32'd4;
                  state_d      = S_REQ;
               end
            end
            default: begin
               state_d = S_REQ;
            end
         endcase
      end
   end

   // State and output registers; reset aborts a fetch without waiting for clk.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_REQ;
         pc_q         <= PC_RESET;
         mem_a_q      <= 32'd0;
         mem_rd_q     <= 1'b0;
         inst_q       <= 32'd0;
         inst_pc_q    <= 32'd0;
         inst_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         mem_a_q      <= mem_a_d;
         mem_rd_q     <= mem_rd_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
         inst_valid_q <= inst_valid_d;
      end
   end

   assign bus.mem_a      = mem_a_q;
   assign bus.mem_rd     = mem_rd_q;
   assign bus.inst       = inst_q;
   assign bus.inst_pc    = inst_pc_q;
   assign bus.inst_valid = inst_valid_q;

endmodule
